// File: rtl/mmc_block_seq_if.sv
// Engine-side handshake bundle between mmc_block_seq and the mmc byte engine.
interface mmc_block_seq_if;
    logic        mmc_speed;
    logic        mmc_rd;
    logic        mmc_wr;
    logic        mmc_init;
    logic        mmc_send;
    logic        mmc_stop;
    logic [47:0] mmc_cmd;
    logic [7:0]  mmc_data_in;
    logic [7:0]  mmc_data_out;
    logic        mmc_done;

    modport master (
        output mmc_speed, mmc_rd, mmc_wr, mmc_init, mmc_send, mmc_stop,
        output mmc_cmd, mmc_data_in,
        input  mmc_data_out, mmc_done
    );

    modport slave (
        input  mmc_speed, mmc_rd, mmc_wr, mmc_init, mmc_send, mmc_stop,
        input  mmc_cmd, mmc_data_in,
        output mmc_data_out, mmc_done
    );
endinterface

// File: rtl/mmc_block_seq.sv
// Single-block read/write sequencer driving the SPI-mode MMC byte engine.
// Define MMC_SEQ_INIT_EN to build in the card initialisation sequence.
module mmc_block_seq #(
    parameter int unsigned BYTE_ADDR   = 0,
    parameter int unsigned RESP_TRIES  = 8,
    parameter int unsigned TOKEN_TRIES = 4096,
    parameter int unsigned BUSY_TRIES  = 65535
) (
    input  logic        mmc_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        write,
    input  logic [31:0] lba,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [8:0]  buf_addr,
    output logic [7:0]  buf_wdata,
    output logic        buf_we,
    input  logic [7:0]  buf_rdata,
    output logic [3:0]  state_out,
    input  logic        init_req,
    mmc_block_seq_if.master eng
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CMD    = 4'd1,
        S_RESP   = 4'd2,
        S_TOKEN  = 4'd3,
        S_RDATA  = 4'd4,
        S_RCRC   = 4'd5,
        S_WTOKEN = 4'd6,
        S_WDATA  = 4'd7,
        S_WCRC   = 4'd8,
        S_WRESP  = 4'd9,
        S_WBUSY  = 4'd10,
        S_STOP   = 4'd11,
`ifdef MMC_SEQ_INIT_EN
        S_INIT   = 4'd13,
`endif
        S_FIN    = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,
        PH_WAIT  = 2'd1,
        PH_PRE   = 2'd2
    } phase_t;

    localparam logic [4:0] OP_RD   = 5'b00001;
    localparam logic [4:0] OP_WR   = 5'b00010;
    localparam logic [4:0] OP_INIT = 5'b00100;
    localparam logic [4:0] OP_SEND = 5'b01000;
    localparam logic [4:0] OP_STOP = 5'b10000;

    localparam logic [16:0] RESP_LIM  = 17'(RESP_TRIES);
    localparam logic [16:0] TOKEN_LIM = 17'(TOKEN_TRIES);
    localparam logic [16:0] BUSY_LIM  = 17'(BUSY_TRIES);

    function automatic logic [47:0] mk_cmd(
        input logic [5:0]  idx,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        return {2'b01, idx, arg, crc, 1'b1};
    endfunction

    state_t      state_q;
    phase_t      ph_q;
    logic [4:0]  strb_q;
    logic [9:0]  cnt_q;
    logic [15:0] tries_q;
    logic [2:0]  code_q;
    logic        wdir_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [2:0]  err_code_q;
    logic [8:0]  buf_addr_q;
    logic [7:0]  buf_wdata_q;
    logic        buf_we_q;
    logic [47:0] cmd_q;
    logic [7:0]  din_q;

    logic [4:0]  op_sel;
    logic [7:0]  rx;
    logic        mdone;
    logic [16:0] tries_nx;
    logic [10:0] cnt_nx;
    logic [31:0] arg;
    logic [2:0]  resp_to;

    assign rx       = eng.mmc_data_out;
    assign mdone    = eng.mmc_done;
    assign tries_nx = {1'b0, tries_q} + 17'd1;
    assign cnt_nx   = {1'b0, cnt_q} + 11'd1;
    assign arg      = (BYTE_ADDR != 0) ? {lba[22:0], 9'd0} : lba;

`ifdef MMC_SEQ_INIT_EN
    typedef enum logic [1:0] {
        M_XFER = 2'd0,
        M_CMD0 = 2'd1,
        M_CMD1 = 2'd2
    } mode_t;

    mode_t mode_q;
    logic  cont_q;
    logic  speed_q;

    assign resp_to       = (mode_q != M_XFER) ? 3'd6 : 3'd2;
    assign eng.mmc_speed = speed_q;
`else
    logic unused_init;

    assign unused_init   = init_req;
    assign resp_to       = 3'd2;
    assign eng.mmc_speed = 1'b1;
`endif

    always_comb begin
        op_sel = 5'd0;
        unique case (state_q)
            S_CMD:    op_sel = OP_SEND;
            S_RESP, S_TOKEN, S_RDATA, S_RCRC, S_WRESP, S_WBUSY:
                      op_sel = OP_RD;
            S_WTOKEN, S_WDATA, S_WCRC:
                      op_sel = OP_WR;
            S_STOP:   op_sel = OP_STOP;
`ifdef MMC_SEQ_INIT_EN
            S_INIT:   op_sel = OP_INIT;
`endif
            default:  op_sel = 5'd0;
        endcase
    end

    always_ff @(posedge mmc_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ph_q        <= PH_ISSUE;
            strb_q      <= 5'd0;
            cnt_q       <= '0;
            tries_q     <= '0;
            code_q      <= 3'd0;
            wdir_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            buf_we_q    <= 1'b0;
            cmd_q       <= '1;
            din_q       <= 8'hFF;
`ifdef MMC_SEQ_INIT_EN
            mode_q      <= M_XFER;
            cont_q      <= 1'b0;
            speed_q     <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            buf_we_q <= 1'b0;
            if (state_q == S_IDLE) begin
`ifdef MMC_SEQ_INIT_EN
                if (init_req) begin
                    state_q    <= S_INIT;
                    busy_q     <= 1'b1;
                    err_q      <= 1'b0;
                    err_code_q <= 3'd0;
                    code_q     <= 3'd0;
                end else
`endif
                if (start) begin
                    state_q    <= S_CMD;
                    busy_q     <= 1'b1;
                    err_q      <= 1'b0;
                    err_code_q <= 3'd0;
                    code_q     <= 3'd0;
                    wdir_q     <= write;
                    cmd_q      <= mk_cmd(write ? 6'd24 : 6'd17,
                                         arg, 7'h7F);
                end
            end else if (state_q == S_FIN) begin
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                err_q      <= (code_q != 3'd0);
                err_code_q <= code_q;
                buf_addr_q <= '0;
`ifdef MMC_SEQ_INIT_EN
                mode_q     <= M_XFER;
`endif
            end else begin
                unique case (ph_q)
                    PH_ISSUE: begin
                        // Data bytes need one extra cycle for the buffer read
                        if (state_q == S_WDATA) begin
                            ph_q <= PH_PRE;
                        end else if (!mdone) begin
                            strb_q <= op_sel;
                            din_q  <= (state_q == S_WTOKEN) ? 8'hFE
                                                            : 8'hFF;
                            ph_q   <= PH_WAIT;
                        end
                    end
                    PH_PRE: begin
                        if (!mdone) begin
                            strb_q <= op_sel;
                            din_q  <= buf_rdata;
                            ph_q   <= PH_WAIT;
                        end
                    end
                    PH_WAIT: begin
                        if (mdone) begin
                            strb_q <= 5'd0;
                            ph_q   <= PH_ISSUE;
                            unique case (state_q)
                                S_CMD: begin
                                    tries_q <= '0;
                                    state_q <= S_RESP;
                                end
                                S_RESP: begin
                                    if (rx == 8'hFF) begin
                                        if (tries_nx == RESP_LIM) begin
                                            code_q  <= resp_to;
                                            state_q <= S_STOP;
                                        end else begin
                                            tries_q <= tries_nx[15:0];
                                        end
                                    end
`ifdef MMC_SEQ_INIT_EN
                                    else if (mode_q == M_CMD0) begin
                                        state_q <= S_STOP;
                                        if (rx == 8'h01) begin
                                            cont_q <= 1'b1;
                                            mode_q <= M_CMD1;
                                            cnt_q  <= '0;
                                            cmd_q  <= mk_cmd(6'd1, 32'd0,
                                                             7'h7F);
                                        end else begin
                                            code_q <= 3'd6;
                                        end
                                    end else if (mode_q == M_CMD1) begin
                                        state_q <= S_STOP;
                                        if (rx == 8'h00) begin
                                            speed_q <= 1'b1;
                                        end else if (rx == 8'h01 &&
                                                     cnt_nx != 11'd1024) begin
                                            cont_q <= 1'b1;
                                            cnt_q  <= cnt_nx[9:0];
                                        end else begin
                                            code_q <= 3'd6;
                                        end
                                    end
`endif
                                    else if (rx == 8'h00) begin
                                        tries_q <= '0;
                                        state_q <= wdir_q ? S_WTOKEN
                                                          : S_TOKEN;
                                    end else begin
                                        code_q  <= 3'd1;
                                        state_q <= S_STOP;
                                    end
                                end
                                S_TOKEN: begin
                                    if (rx == 8'hFE) begin
                                        cnt_q   <= '0;
                                        state_q <= S_RDATA;
                                    end else if (tries_nx == TOKEN_LIM) begin
                                        code_q  <= 3'd3;
                                        state_q <= S_STOP;
                                    end else begin
                                        tries_q <= tries_nx[15:0];
                                    end
                                end
                                S_RDATA: begin
                                    buf_we_q    <= 1'b1;
                                    buf_addr_q  <= cnt_q[8:0];
                                    buf_wdata_q <= rx;
                                    if (cnt_nx == 11'd512) begin
                                        cnt_q   <= '0;
                                        state_q <= S_RCRC;
                                    end else begin
                                        cnt_q <= cnt_nx[9:0];
                                    end
                                end
                                S_RCRC: begin
                                    if (cnt_q[0]) begin
                                        cnt_q   <= '0;
                                        state_q <= S_STOP;
                                    end else begin
                                        cnt_q <= 10'd1;
                                    end
                                end
                                S_WTOKEN: begin
                                    cnt_q      <= '0;
                                    buf_addr_q <= '0;
                                    state_q    <= S_WDATA;
                                end
                                S_WDATA: begin
                                    buf_addr_q <= cnt_nx[8:0];
                                    if (cnt_nx == 11'd512) begin
                                        cnt_q   <= '0;
                                        state_q <= S_WCRC;
                                    end else begin
                                        cnt_q <= cnt_nx[9:0];
                                    end
                                end
                                S_WCRC: begin
                                    if (cnt_q[0]) begin
                                        cnt_q   <= '0;
                                        state_q <= S_WRESP;
                                    end else begin
                                        cnt_q <= 10'd1;
                                    end
                                end
                                S_WRESP: begin
                                    tries_q <= '0;
                                    if (rx[4:0] != 5'h05) begin
                                        code_q  <= 3'd4;
                                        state_q <= S_STOP;
                                    end else begin
                                        state_q <= S_WBUSY;
                                    end
                                end
                                S_WBUSY: begin
                                    if (rx != 8'h00) begin
                                        state_q <= S_STOP;
                                    end else if (tries_nx == BUSY_LIM) begin
                                        code_q  <= 3'd5;
                                        state_q <= S_STOP;
                                    end else begin
                                        tries_q <= tries_nx[15:0];
                                    end
                                end
                                S_STOP: begin
`ifdef MMC_SEQ_INIT_EN
                                    if (cont_q) begin
                                        cont_q  <= 1'b0;
                                        state_q <= S_CMD;
                                    end else
`endif
                                    state_q <= S_FIN;
                                end
`ifdef MMC_SEQ_INIT_EN
                                S_INIT: begin
                                    mode_q  <= M_CMD0;
                                    cmd_q   <= mk_cmd(6'd0, 32'd0, 7'h4A);
                                    state_q <= S_CMD;
                                end
`endif
                                default: state_q <= S_STOP;
                            endcase
                        end
                    end
                    default: ph_q <= PH_ISSUE;
                endcase
            end
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign err_code        = err_code_q;
    assign buf_addr        = buf_addr_q;
    assign buf_wdata       = buf_wdata_q;
    assign buf_we          = buf_we_q;
    assign state_out       = state_q;
    assign eng.mmc_rd      = strb_q[0];
    assign eng.mmc_wr      = strb_q[1];
    assign eng.mmc_init    = strb_q[2];
    assign eng.mmc_send    = strb_q[3];
    assign eng.mmc_stop    = strb_q[4];
    assign eng.mmc_cmd     = cmd_q;
    assign eng.mmc_data_in = din_q;

endmodule

// File: tb/tb_mmc_block_seq.sv
// Bench for mmc_block_seq: card/engine model, block buffer and scoreboards.
module tb_mmc_block_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        write = 1'b0;
    logic [31:0] lba = '0;
    logic        init_req = 1'b0;
    logic        busy, done, err, buf_we;
    logic [2:0]  err_code;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic [7:0]  buf_rdata = '0;
    logic [3:0]  state_out;
    logic [4:0]  strb;

    mmc_block_seq_if eng ();

    mmc_block_seq dut (
        .mmc_clk   (clk),
        .reset     (reset),
        .start     (start),
        .write     (write),
        .lba       (lba),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .buf_we    (buf_we),
        .buf_rdata (buf_rdata),
        .state_out (state_out),
        .init_req  (init_req),
        .eng       (eng)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_rd, n_wr, n_init, n_send, n_stop, n_multi;
    bit pend;

    logic [7:0]  mem [512];
    logic [7:0]  rdq [$];
    logic [7:0]  wrq [$];
    logic [7:0]  exp_wr [$];
    logic [47:0] cmdq [$];
    logic [16:0] obs_buf [$];
    logic [16:0] exp_buf [$];

    assign strb = {eng.mmc_stop, eng.mmc_send, eng.mmc_init,
                   eng.mmc_wr, eng.mmc_rd};

    always @(posedge clk) begin
        buf_rdata <= mem[buf_addr];
        if (buf_we) mem[buf_addr] <= buf_wdata;
    end

    // Card + engine model: one-cycle latency, four-phase done
    initial begin
        eng.mmc_done = 1'b0;
        eng.mmc_data_out = 8'hFF;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (buf_we) obs_buf.push_back({buf_addr, buf_wdata});
            if (reset) begin
                eng.mmc_done = 1'b0;
                pend = 1'b0;
            end else if (eng.mmc_done) begin
                if (strb == 5'd0) eng.mmc_done = 1'b0;
            end else if (pend) begin
                pend = 1'b0;
                if ($countones(strb) > 1) n_multi++;
                if (strb[0]) begin
                    n_rd++;
                    eng.mmc_data_out = (rdq.size() != 0) ? rdq.pop_front()
                                                         : 8'hFF;
                end
                if (strb[1]) begin
                    n_wr++;
                    wrq.push_back(eng.mmc_data_in);
                end
                if (strb[2]) n_init++;
                if (strb[3]) begin
                    n_send++;
                    cmdq.push_back(eng.mmc_cmd);
                end
                if (strb[4]) n_stop++;
                eng.mmc_done = 1'b1;
            end else if (strb != 5'd0) begin
                pend = 1'b1;
            end
        end
    end

    task automatic clear_log();
        n_rd = 0; n_wr = 0; n_init = 0;
        n_send = 0; n_stop = 0; n_multi = 0;
        rdq.delete(); wrq.delete(); exp_wr.delete();
        cmdq.delete(); obs_buf.delete(); exp_buf.delete();
    endtask

    task automatic start_xfer(input logic wr, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1;
        write = wr;
        lba = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        int i = 0;
        ok = 1'b0;
        while (!ok && i < lim) begin
            @(negedge clk);
            i++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset(input string nm);
        logic spd;
`ifdef MMC_SEQ_INIT_EN
        spd = 1'b0;
`else
        spd = 1'b1;
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (strb !== 5'd0) begin
            n_fail++;
            $display("FAIL %s strobes: got %b want 00000", nm, strb);
        end
        n_chk++;
        if ({busy, done, err, buf_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s busy/done/err/we: got %b want 0000", nm,
                     {busy, done, err, buf_we});
        end
        n_chk++;
        if (err_code !== 3'd0 || buf_addr !== 9'd0) begin
            n_fail++;
            $display("FAIL %s code/addr: got %0d/%0d want 0/0", nm,
                     err_code, buf_addr);
        end
        n_chk++;
        if (eng.mmc_cmd !== 48'hFFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL %s mmc_cmd: got %h want all-ones", nm,
                     eng.mmc_cmd);
        end
        n_chk++;
        if (eng.mmc_data_in !== 8'hFF) begin
            n_fail++;
            $display("FAIL %s data_in: got %h want ff", nm,
                     eng.mmc_data_in);
        end
        n_chk++;
        if (state_out !== 4'd0) begin
            n_fail++;
            $display("FAIL %s state_out: got %0d want 0", nm, state_out);
        end
        n_chk++;
        if (eng.mmc_speed !== spd) begin
            n_fail++;
            $display("FAIL %s speed: got %b want %b", nm,
                     eng.mmc_speed, spd);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read(input logic [31:0] a, input string nm);
        bit ok;
        logic [16:0] got, want;
        logic [47:0] ecmd;
        clear_log();
        ecmd = {2'b01, 6'd17, a, 7'h7F, 1'b1};
        rdq.push_back(8'h00);
        repeat (3) rdq.push_back(8'hFF);
        rdq.push_back(8'hFE);
        for (int i = 0; i < 512; i++) begin
            rdq.push_back(8'(i % 256));
            exp_buf.push_back({9'(i), 8'(i % 256)});
        end
        rdq.push_back(8'h12);
        rdq.push_back(8'h34);
        start_xfer(1'b0, a);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_rise: got %b want 1", nm, busy);
        end
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20000, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s done_timeout: got none want done", nm);
        end
        n_chk++;
        if ({busy, err, err_code, buf_addr} !== 13'd0) begin
            n_fail++;
            $display("FAIL %s done_state: busy %b err %b code %0d addr %0d want 0",
                     nm, busy, err, err_code, buf_addr);
        end
        n_chk++;
        if (obs_buf.size() != 512) begin
            n_fail++;
            $display("FAIL %s we_count: got %0d want 512", nm,
                     obs_buf.size());
        end
        while (obs_buf.size() != 0 && exp_buf.size() != 0) begin
            got = obs_buf.pop_front();
            want = exp_buf.pop_front();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s buf_write: got %h want %h", nm, got, want);
            end
        end
        n_chk++;
        if (n_send != 1 || cmdq.size() == 0 || cmdq[0] !== ecmd) begin
            n_fail++;
            $display("FAIL %s cmd: sends %0d got %h want %h", nm, n_send,
                     (cmdq.size() != 0) ? cmdq[0] : 48'h0, ecmd);
        end
        n_chk++;
        if (n_stop != 1 || n_multi != 0 || rdq.size() != 0) begin
            n_fail++;
            $display("FAIL %s ops: stop %0d multi %0d left %0d want 1/0/0",
                     nm, n_stop, n_multi, rdq.size());
        end
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: got %b want 0", nm, done);
        end
    endtask

    task automatic test_write();
        bit ok;
        logic [7:0] got, want;
        clear_log();
        for (int i = 0; i < 512; i++) mem[i] = 8'hA5;
        rdq.push_back(8'h00);
        rdq.push_back(8'hE5);
        repeat (10) rdq.push_back(8'h00);
        rdq.push_back(8'hFF);
        exp_wr.push_back(8'hFE);
        repeat (512) exp_wr.push_back(8'hA5);
        exp_wr.push_back(8'hFF);
        exp_wr.push_back(8'hFF);
        start_xfer(1'b1, 32'h0000_0055);
        wait_done(20000, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL write done_timeout: got none want done");
        end
        n_chk++;
        if (err !== 1'b0 || err_code !== 3'd0) begin
            n_fail++;
            $display("FAIL write err: got %b/%0d want 0/0", err, err_code);
        end
        n_chk++;
        if (wrq.size() != 515) begin
            n_fail++;
            $display("FAIL write wr_count: got %0d want 515", wrq.size());
        end
        while (wrq.size() != 0 && exp_wr.size() != 0) begin
            got = wrq.pop_front();
            want = exp_wr.pop_front();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL write card_byte: got %h want %h", got, want);
            end
        end
        n_chk++;
        if (cmdq.size() == 0 || cmdq[0][45:40] !== 6'd24 || n_rd != 13) begin
            n_fail++;
            $display("FAIL write cmd/rd: sends %0d rd %0d want CMD24/13",
                     cmdq.size(), n_rd);
        end
    endtask

    task automatic test_resp_errors();
        bit ok;
        clear_log();
        start_xfer(1'b0, 32'h10);
        wait_done(2000, ok);
        n_chk++;
        if (!ok || err !== 1'b1 || err_code !== 3'd2) begin
            n_fail++;
            $display("FAIL resp_timeout: done %b err %b code %0d want 1/1/2",
                     ok, err, err_code);
        end
        n_chk++;
        if (n_rd != 8 || n_stop != 1) begin
            n_fail++;
            $display("FAIL resp_timeout ops: rd %0d stop %0d want 8/1",
                     n_rd, n_stop);
        end
        clear_log();
        rdq.push_back(8'hFF);
        rdq.push_back(8'h04);
        start_xfer(1'b0, 32'h11);
        wait_done(2000, ok);
        n_chk++;
        if (!ok || err !== 1'b1 || err_code !== 3'd1 || n_stop != 1) begin
            n_fail++;
            $display("FAIL r1_nonzero: done %b err %b code %0d stop %0d want 1/1/1/1",
                     ok, err, err_code, n_stop);
        end
    endtask

    task automatic test_data_reject();
        bit ok;
        clear_log();
        rdq.push_back(8'h00);
        rdq.push_back(8'h0B);
        start_xfer(1'b1, 32'h20);
        wait_done(20000, ok);
        n_chk++;
        if (!ok || err !== 1'b1 || err_code !== 3'd4) begin
            n_fail++;
            $display("FAIL data_reject: done %b err %b code %0d want 1/1/4",
                     ok, err, err_code);
        end
        n_chk++;
        if (n_stop != 1 || n_rd != 2 || wrq.size() != 515) begin
            n_fail++;
            $display("FAIL data_reject ops: stop %0d rd %0d wr %0d want 1/2/515",
                     n_stop, n_rd, wrq.size());
        end
    endtask

    task automatic test_reset_mid();
        int i = 0;
        clear_log();
        rdq.push_back(8'h00);
        rdq.push_back(8'hFE);
        for (int k = 0; k < 512; k++) rdq.push_back(8'(k));
        start_xfer(1'b0, 32'h30);
        while (obs_buf.size() < 100 && i < 5000) begin
            @(negedge clk);
            i++;
        end
        n_chk++;
        if (obs_buf.size() < 100) begin
            n_fail++;
            $display("FAIL reset_mid reach_byte100: got %0d want 100",
                     obs_buf.size());
        end
        test_reset("reset_mid");
        test_read(32'h0000_0777, "read_after_reset");
    endtask

`ifdef MMC_SEQ_INIT_EN
    task automatic test_init();
        bit ok;
        int c0 = 0, c1 = 0, cx = 0;
        clear_log();
        rdq.push_back(8'h01);
        repeat (3) rdq.push_back(8'h01);
        rdq.push_back(8'h00);
        @(negedge clk);
        init_req = 1'b1;
        start = 1'b1;
        write = 1'b0;
        @(negedge clk);
        init_req = 1'b0;
        start = 1'b0;
        wait_done(5000, ok);
        foreach (cmdq[k]) begin
            if (cmdq[k] === {2'b01, 6'd0, 32'd0, 7'h4A, 1'b1}) c0++;
            else if (cmdq[k][45:40] === 6'd1) c1++;
            else cx++;
        end
        n_chk++;
        if (!ok || err !== 1'b0 || err_code !== 3'd0) begin
            n_fail++;
            $display("FAIL init done: done %b err %b code %0d want 1/0/0",
                     ok, err, err_code);
        end
        n_chk++;
        if (c0 != 1 || c1 != 4 || cx != 0 || n_init != 1) begin
            n_fail++;
            $display("FAIL init cmds: cmd0 %0d cmd1 %0d other %0d init %0d want 1/4/0/1",
                     c0, c1, cx, n_init);
        end
        n_chk++;
        if (eng.mmc_speed !== 1'b1 || n_stop != 5) begin
            n_fail++;
            $display("FAIL init speed/stop: got %b/%0d want 1/5",
                     eng.mmc_speed, n_stop);
        end
    endtask
`else
    task automatic test_init_ignored();
        clear_log();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || state_out !== 4'd0 || n_init + n_send != 0) begin
            n_fail++;
            $display("FAIL init_ignored: busy %b state %0d ops %0d want 0/0/0",
                     busy, state_out, n_init + n_send);
        end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_log();
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        test_reset("reset");
        test_read(32'h0000_1234, "read");
        test_write();
        test_resp_errors();
        test_data_reject();
        test_reset_mid();
`ifdef MMC_SEQ_INIT_EN
        test_init();
`else
        test_init_ignored();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mmc_block_seq.md
# mmc_block_seq

Block-transfer sequencer for the SPI-mode MMC byte engine (`mmc`), running entirely in the `mmc_clk` domain. It turns a single host request (read or write one 512-byte block at a given LBA) into the required sequence of engine operations: command, response polling, data token, data bytes, CRC, data response, busy wait and stop. Bytes move through an external 512x8 block buffer. Host-side clock-domain crossing is handled outside this block.

## Interface
Parameters:
- `BYTE_ADDR`, default 0. 1: command argument = `lba<<9`; 0: argument = `lba`.
- `RESP_TRIES`, default 8. Maximum reads while polling for the R1 response.
- `TOKEN_TRIES`, default 4096. Maximum reads while polling for the `0xFE` token.
- `BUSY_TRIES`, default 65535. Maximum reads while polling busy after a write.

Ports:
- `mmc_clk` in 1: clock. All logic is posedge `mmc_clk`.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request pulse.
- `write` in 1: 1 = write block, 0 = read block. Sampled with `start`.
- `lba` in 32: block address. Sampled with `start`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; held until the next `start`.
- `err_code` out 3: 0 ok, 1 R1 nonzero, 2 response timeout, 3 token timeout, 4 data response reject, 5 busy timeout, 6 init fail.
- `buf_addr` out 9: buffer byte address.
- `buf_wdata` out 8: read data going to the buffer.
- `buf_we` out 1: buffer write strobe.
- `buf_rdata` in 8: buffer read data, 1-cycle latency from `buf_addr`.
- `mmc_speed`, `mmc_rd`, `mmc_wr`, `mmc_init`, `mmc_send`, `mmc_stop` out 1 each: engine controls.
- `mmc_cmd` out 48: engine command.
- `mmc_data_in` out 8: engine write byte.
- `mmc_data_out` in 8: engine read byte.
- `mmc_done` in 1: engine completion.
- `state_out` out 4: current state encoding, for debug.
- `init_req` in 1: card initialisation request (pulse; see Configuration).

## Operation
Engine handshake (4-phase):
- At most one of `rd`, `wr`, `init`, `send`, `stop` is high at a time.
- `mmc_cmd` and `mmc_data_in` are stable while the strobe is high.
- The strobe is held until `mmc_done`=1 and dropped the next cycle.
- The sequencer waits for `mmc_done`=0 before raising the next strobe.
- `mmc_data_out` is captured in the cycle `mmc_done`=1 is first seen.

Command format: `{2'b01, idx[5:0], arg[31:0], crc7, 1'b1}`. crc7 = `7'h4A` for CMD0; all other commands use `7'h7F`.

States: IDLE, CMD, RESP, TOKEN, RDATA, RCRC, WTOKEN, WDATA, WCRC, WRESP, WBUSY, STOP, FIN, plus INIT states (see Configuration).
- IDLE→CMD on `start` when `busy`=0. Sends CMD17 for a read or CMD24 for a write. `start` while busy is ignored.
- RESP: repeat `rd` until the byte is not `0xFF`.
  - After `RESP_TRIES` reads with no response: error 2.
  - Byte ≠ `0x00`: error 1.
  - Otherwise go to TOKEN (read) or WTOKEN (write).
- Read path:
  - TOKEN: `rd` until the byte is `0xFE`. After `TOKEN_TRIES` reads: error 3.
  - RDATA: 512 `rd` ops. Each byte is written to the buffer with `buf_we`=1 for one cycle at `buf_addr`=0..511.
  - RCRC: 2 `rd` ops; the bytes are discarded.
- Write path:
  - WTOKEN: `wr` `0xFE`.
  - WDATA: 512 `wr` ops. `buf_addr` is driven at least 2 cycles before `wr` rises, and `buf_rdata` is latched into `mmc_data_in`.
  - WCRC: `wr` `0xFF` twice.
  - WRESP: one `rd`. If `(b & 0x1F)` ≠ `0x05`: error 4.
  - WBUSY: `rd` until the byte ≠ `0x00`. After `BUSY_TRIES` reads: error 5.
- Every path, including every error, passes through STOP (one `stop` op), then FIN, then IDLE.
- Byte counter is 10 bits; the terminal count is 512. `buf_addr` wraps to 0 at FIN.

## Timing
- Reset values: all strobes 0, `busy` 0, `done` 0, `err` 0, `err_code` 0, `buf_we` 0, `buf_addr` 0, `mmc_cmd` all-ones, `mmc_data_in` `0xFF`, `state_out` IDLE.
- `mmc_speed` resets to 0 when the INIT feature is compiled in, and to 1 when it is not.
- `busy` rises the cycle after `start` is accepted and falls in the same cycle `done` pulses.
- `err` and `err_code` update in the same cycle as `done`.
- Reset mid-transfer: all outputs return to reset values on the next edge. No stop op is issued; the engine shares the same reset.
- Simultaneous `start` and `init_req` in IDLE: `init_req` wins and `start` is dropped.

## Configuration
`MMC_SEQ_INIT_EN` defined:
- `init_req` in IDLE runs the init sequence: `init` op, CMD0 (expect R1 `0x01`), then CMD1 repeated until R1 = `0x00`, with up to 1024 attempts and a `stop` between each.
- Any failure gives error 6.
- On success, `mmc_speed` is set to 1 and stays 1 until reset.
- The sequence ends with a `done` pulse.

`MMC_SEQ_INIT_EN` undefined:
- `init_req` is ignored and no INIT states exist.
- `mmc_speed` is constant 1.

## Test plan
- Read, card model returns R1 `0x00`, 3×`0xFF`, then `0xFE`, bytes 0..255,0..255, CRC → buffer holds the pattern, exactly 512 `buf_we` pulses, `done` with `err`=0, `err_code`=0.
- Write, buffer preloaded with `0xA5`, data response `0xE5`, 10 busy bytes → card sees `0xFE`, 512×`0xA5`, `0xFF`,`0xFF`; `err`=0.
- Read, R1 never leaves `0xFF` → exactly 8 `rd` ops after CMD, then one `stop`, `err_code`=2.
- Write, data response `0x0B` → `err_code`=4; STOP issued before `done`.
- `reset` asserted during RDATA at byte 100 → next edge: all outputs at reset values; a following read completes normally.
- `MMC_SEQ_INIT_EN`: CMD1 returns `0x01` three times then `0x00` → 4 CMD1 sends, `mmc_speed`=1, `err`=0.
